// File: rtl/quantser_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | quantser_pkg                                                     |
// | Shared state encodings and helpers for the quantizer serializer. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package quantser_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Limit a requested bit count to the widest word a lane can hold.
    function automatic logic [31:0] clamp_bw(input logic [31:0] bw, input logic [31:0] bwmax);
        return (bw >= bwmax) ? (bwmax - 32'd1) : bw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/quantser_lane.sv
`default_nettype none
// +------------------------------------------------------------------+
// | quantser_lane                                                    |
// | One serializer lane: active + pending word, registered bit out.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module quantser_lane #(
    parameter int BWOUT   = 32,
    parameter int BWBWOUT = $clog2(BWOUT)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               load,
    input  logic               capture,
    input  logic               promote,
    input  logic               step,
    input  logic [BWBWOUT-1:0] sel,
    input  logic [BWOUT-1:0]   din,
    output logic               dout
);

    logic [BWOUT-1:0] r_act;
    logic [BWOUT-1:0] r_pend;
    logic             r_dout;

    // The sequencer never raises capture together with load or promote.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_act  <= '0;
            r_pend <= '0;
            r_dout <= 1'b0;
        end else begin
            if (capture) r_pend <= din;
            if (load) begin
                r_act  <= din;
                r_dout <= din[sel];
            end else if (promote) begin
                r_act  <= r_pend;
                r_dout <= r_pend[sel];
            end else if (step) begin
                r_dout <= r_act[sel];
            end
        end
    end

    assign dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/quantser_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | quantser_seq                                                     |
// | Multi-lane bit-serial sequencer with one-deep pending slot.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module quantser_seq
    import quantser_pkg::*;
#(
    parameter int NLANES  = 64,
    parameter int BWOUT   = 32,
    parameter int BWBWOUT = $clog2(BWOUT)
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    start,
    output logic                    start_rdy,
    input  logic [BWBWOUT-1:0]      bwout,
    input  logic                    msbfirst,
    input  logic [NLANES*BWOUT-1:0] din,
    input  logic                    stall,
    output logic [NLANES-1:0]       dout,
    output logic                    dvalid,
    output logic [BWBWOUT-1:0]      bitidx,
    output logic                    last,
    output logic                    done,
    output logic                    busy
);

    logic [0:0]         r_state;
    logic               r_pend_full;
    logic               r_msb_act;
    logic               r_msb_pend;
    logic [BWBWOUT-1:0] r_bw_act;
    logic [BWBWOUT-1:0] r_bw_pend;
    logic [BWBWOUT-1:0] r_bitidx;
    logic               r_last;
    logic               r_done;

    logic               w_shift;
    logic               w_acc;
    logic               w_adv;
    logic               w_final;
    logic               w_load;
    logic               w_capture;
    logic               w_promote;
    logic               w_step;
    logic               w_to_idle;
    logic [BWBWOUT-1:0] w_bw_in;
    logic [BWBWOUT-1:0] w_nidx;
    logic [BWBWOUT-1:0] w_nbw;
    logic               w_nmsb;
    logic               w_nlast;

    assign w_shift   = (r_state == ST_SHIFT);
    assign start_rdy = !stall && !r_pend_full;
    assign w_acc     = start && start_rdy;
    assign w_adv     = w_shift && !stall;
    assign w_final   = w_adv && r_last;
    assign w_bw_in   = BWBWOUT'(clamp_bw(32'(bwout), 32'(BWOUT)));

    // A start lands in the active slot when idle or exactly on a final bit with nothing queued.
    assign w_load    = w_acc && (!w_shift || (r_last && !r_pend_full));
    assign w_capture = w_acc && w_shift && !r_last;
    assign w_promote = w_final && r_pend_full;
    assign w_step    = w_adv && !r_last;
    assign w_to_idle = w_final && !r_pend_full && !w_acc;

    always_comb begin
        w_nidx = r_bitidx;
        w_nbw  = r_bw_act;
        w_nmsb = r_msb_act;
        if (w_load) begin
            w_nbw  = w_bw_in;
            w_nmsb = msbfirst;
            w_nidx = msbfirst ? w_bw_in : '0;
        end else if (w_promote) begin
            w_nbw  = r_bw_pend;
            w_nmsb = r_msb_pend;
            w_nidx = r_msb_pend ? r_bw_pend : '0;
        end else if (w_step) begin
            w_nidx = r_msb_act ? (r_bitidx - BWBWOUT'(1)) : (r_bitidx + BWBWOUT'(1));
        end
        w_nlast = w_nmsb ? (w_nidx == '0) : (w_nidx == w_nbw);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= ST_IDLE;
            r_pend_full <= 1'b0;
            r_msb_act   <= 1'b0;
            r_msb_pend  <= 1'b0;
            r_bw_act    <= '0;
            r_bw_pend   <= '0;
            r_bitidx    <= '0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_load || w_promote) r_state <= ST_SHIFT;
            else if (w_to_idle)      r_state <= ST_IDLE;

            if (w_capture) begin
                r_pend_full <= 1'b1;
                r_bw_pend   <= w_bw_in;
                r_msb_pend  <= msbfirst;
            end else if (w_promote) begin
                r_pend_full <= 1'b0;
            end

            if (w_load || w_promote || w_step) begin
                r_bitidx  <= w_nidx;
                r_last    <= w_nlast;
                r_bw_act  <= w_nbw;
                r_msb_act <= w_nmsb;
            end else if (w_to_idle) begin
                r_last <= 1'b0;
            end

            // Pulse owed after a final bit is held through any stall.
            if (w_final)     r_done <= 1'b1;
            else if (!stall) r_done <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
            quantser_lane #(
                .BWOUT   (BWOUT),
                .BWBWOUT (BWBWOUT)
            ) u_lane (
                .clk     (clk),
                .clr     (clr),
                .load    (w_load),
                .capture (w_capture),
                .promote (w_promote),
                .step    (w_step),
                .sel     (w_nidx),
                .din     (din[gi*BWOUT +: BWOUT]),
                .dout    (dout[gi])
            );
        end
    endgenerate

    assign dvalid = w_adv;
    assign bitidx = r_bitidx;
    assign last   = r_last;
    assign done   = r_done && !stall;
    assign busy   = w_shift || r_pend_full;

endmodule
`default_nettype wire
